multicycle_control: RTL and testbench

- Moore-FSM main control unit for the 16-bit multi-cycle processor.
- Consumes the 3-bit opcode (IR[15:13]) from the datapath and drives every datapath control strobe.
- Sequences each instruction through the fetch, decode, execute, memory and write-back steps.
- Also provides a retired-instruction counter, an illegal-opcode pulse and a state-debug output.

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave):
// opcode in, every datapath strobe plus debug/status signals out.
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       opcode;
  logic [1:0]       ALUOp;
  logic [1:0]       ALUSrcB;
  logic [1:0]       PCSource;
  logic             RegDst;
  logic             MemtoReg;
  logic             MemRead;
  logic             MemWrite;
  logic             IorD;
  logic             RegWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             ALUSrcA;
  logic [3:0]       state;
  logic             illegal_op;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode,
    output ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite, IorD,
           RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
           state, illegal_op, halted, instr_count
  );

  modport slave (
    output opcode,
    input  ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite, IorD,
           RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
           state, illegal_op, halted, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore main control FSM for the 16-bit multi-cycle processor, with retired-instruction
// counter and illegal-opcode pulse. Define MULTICYCLE_CONTROL_HALT_EN to add the HALT state.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input logic             clock,
  input logic             reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
`ifdef MULTICYCLE_CONTROL_HALT_EN
    , S_HALT  = 4'd12
`endif
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       memto_reg;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       alu_src_a;
  } ctrl_t;

  state_t           state_q;
  state_t           next_state;
  ctrl_t            ctrl;
  logic             illegal;
  logic             retire;
  logic [CNT_W-1:0] count_q;
`ifdef MULTICYCLE_CONTROL_HALT_EN
  logic             halt_flag;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    ctrl       = '0;
    next_state = S_FETCH;
    illegal    = 1'b0;
    retire     = 1'b0;
`ifdef MULTICYCLE_CONTROL_HALT_EN
    halt_flag  = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.pc_write  = 1'b1;
        next_state     = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        ctrl.alu_src_b = 2'b11;
        case (bus.opcode)
          3'b000:         next_state = S_EXEC;
          3'b001, 3'b010: next_state = S_MEMADDR;
          3'b011:         next_state = S_BRANCH;
          3'b100:         next_state = S_JUMP;
          3'b101:         next_state = S_ADDIEX;
`ifdef MULTICYCLE_CONTROL_HALT_EN
          3'b111: begin
            next_state = S_HALT;
            retire     = 1'b1;
          end
`endif
          default:        illegal    = 1'b1;
        endcase
      end
      S_MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        next_state     = (bus.opcode == 3'b010) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        next_state    = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.memto_reg = 1'b1;
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        retire         = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        next_state     = S_RWB;
      end
      S_RWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        retire             = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
        retire         = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        next_state     = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_HALT_EN
      S_HALT: begin
        next_state = S_HALT;
        halt_flag  = 1'b1;
      end
`endif
      default: next_state = S_FETCH;
    endcase

    // Reset gates every strobe immediately so no write can slip out before the edge.
    if (reset) begin
      ctrl    = '0;
      illegal = 1'b0;
    end
  end

  // NOTE: reset is synchronous here; it is sampled only on the rising clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q <= next_state;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemtoReg    = ctrl.memto_reg;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IorD        = ctrl.iord;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.state       = state_q;
  assign bus.illegal_op  = illegal;
  assign bus.instr_count = count_q;
`ifdef MULTICYCLE_CONTROL_HALT_EN
  assign bus.halted      = halt_flag;
`else
  assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each instruction pushes its expected per-cycle
// state/strobe/count trace, which is popped and compared cycle by cycle mid-cycle.
module tb_multicycle_control;
  localparam int CNT_W = 16;

  logic clock = 1'b0;
  logic reset;

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();
  multicycle_control #(.CNT_W(CNT_W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       memto_reg;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       alu_src_a;
  } ctrl_t;

  typedef struct packed {
    logic [3:0]       st;
    ctrl_t            ctrl;
    logic             ill;
    logic             hlt;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  obs_t             sb[$];
  int               checks   = 0;
  int               failures = 0;
  logic [CNT_W-1:0] count_exp;
  obs_t             got, exp;

  // Strobe table written straight from the per-state control listing.
  function automatic ctrl_t model_ctrl(input int st);
    ctrl_t c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_write = 1; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.memto_reg = 1; c.reg_write = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_dst = 1; c.reg_write = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: c.reg_write = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.st   = bus.state;
    o.ctrl = {bus.ALUOp, bus.ALUSrcB, bus.PCSource, bus.RegDst, bus.MemtoReg, bus.MemRead,
              bus.MemWrite, bus.IorD, bus.RegWrite, bus.IRWrite, bus.PCWrite,
              bus.PCWriteCond, bus.ALUSrcA};
    o.ill  = bus.illegal_op;
    o.hlt  = bus.halted;
    o.cnt  = bus.instr_count;
    return o;
  endfunction

  // Drives the opcode and pushes the expected trace from FETCH to the last state.
  task automatic push_instr(input logic [2:0] op, input int halt_cycles);
    int seq[$];
    bit illegal = 0;
    seq = {0, 1};
    case (op)
      3'b000: begin seq.push_back(6); seq.push_back(7); end
      3'b001: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      3'b010: begin seq.push_back(2); seq.push_back(5); end
      3'b011: seq.push_back(8);
      3'b100: seq.push_back(9);
      3'b101: begin seq.push_back(10); seq.push_back(11); end
`ifdef MULTICYCLE_CONTROL_HALT_EN
      3'b111: repeat (halt_cycles) seq.push_back(12);
`endif
      default: illegal = 1;
    endcase
    bus.opcode = op;
    foreach (seq[i]) begin
      obs_t e;
      e.st   = 4'(seq[i]);
      e.ctrl = model_ctrl(seq[i]);
      e.ill  = illegal && (seq[i] == 1);
      e.hlt  = (seq[i] == 12);
      e.cnt  = (seq[i] == 12) ? count_exp + CNT_W'(1) : count_exp;
      sb.push_back(e);
    end
    if (!illegal) count_exp = count_exp + CNT_W'(1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.opcode = 3'b000;
    repeat (2) @(negedge clock);
    #1;
    got = observe();
    checks++;
    if (got.st !== 4'd0 || got.ctrl !== '0 || got.ill !== 1'b0 || got.cnt !== '0) begin
      failures++;
      $display("FAIL reset_hold: got st=%0d ctrl=%h ill=%b cnt=%0d, want st=0 ctrl=0 ill=0 cnt=0",
               got.st, got.ctrl, got.ill, got.cnt);
    end
    reset = 1'b0;
    #1;
    count_exp = '0;
    got = observe();
    checks++;
    if (got.ctrl !== model_ctrl(0)) begin
      failures++;
      $display("FAIL reset_first_fetch: got ctrl=%h, want %h", got.ctrl, model_ctrl(0));
    end
  endtask

  task automatic test_lw;
    push_instr(3'b001, 0);
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL lw_trace: got st=%0d ctrl=%h ill=%b hlt=%b cnt=%0d, want st=%0d ctrl=%h ill=%b hlt=%b cnt=%0d",
                 got.st, got.ctrl, got.ill, got.hlt, got.cnt, exp.st, exp.ctrl, exp.ill, exp.hlt, exp.cnt);
      end
      @(negedge clock); #1;
    end
    checks++;
    if (bus.instr_count !== CNT_W'(1)) begin
      failures++;
      $display("FAIL lw_count: got %0d, want 1", bus.instr_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops[5];
    ops = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101};
    foreach (ops[k]) begin
      push_instr(ops[k], 0);
      while (sb.size() > 0) begin
        exp = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL b2b_op%0d_trace: got st=%0d ctrl=%h ill=%b hlt=%b cnt=%0d, want st=%0d ctrl=%h ill=%b hlt=%b cnt=%0d",
                   ops[k], got.st, got.ctrl, got.ill, got.hlt, got.cnt, exp.st, exp.ctrl, exp.ill, exp.hlt, exp.cnt);
        end
        @(negedge clock); #1;
      end
    end
    checks++;
    if (bus.instr_count !== count_exp || bus.state !== 4'd0) begin
      failures++;
      $display("FAIL b2b_end: got cnt=%0d st=%0d, want cnt=%0d st=0", bus.instr_count, bus.state, count_exp);
    end
  endtask

  task automatic test_illegal;
    push_instr(3'b110, 0);
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL illegal_trace: got st=%0d ctrl=%h ill=%b cnt=%0d, want st=%0d ctrl=%h ill=%b cnt=%0d",
                 got.st, got.ctrl, got.ill, got.cnt, exp.st, exp.ctrl, exp.ill, exp.cnt);
      end
      @(negedge clock); #1;
    end
    checks++;
    if (bus.state !== 4'd0 || bus.illegal_op !== 1'b0 || bus.instr_count !== count_exp) begin
      failures++;
      $display("FAIL illegal_after: got st=%0d ill=%b cnt=%0d, want st=0 ill=0 cnt=%0d",
               bus.state, bus.illegal_op, bus.instr_count, count_exp);
    end
  endtask

  task automatic test_reset_mid_exec;
    bus.opcode = 3'b000;
    repeat (2) begin @(negedge clock); #1; end
    checks++;
    if (bus.state !== 4'd6) begin
      failures++;
      $display("FAIL mid_exec_reach: got st=%0d, want 6", bus.state);
    end
    reset = 1'b1;
    #1;
    got = observe();
    checks++;
    if (got.ctrl !== '0 || got.ill !== 1'b0) begin
      failures++;
      $display("FAIL mid_exec_gate: got ctrl=%h ill=%b, want 0 0", got.ctrl, got.ill);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      got = observe();
      checks++;
      if (got.ctrl !== '0 || got.st !== 4'd0 || got.cnt !== '0) begin
        failures++;
        $display("FAIL mid_exec_hold%0d: got st=%0d ctrl=%h cnt=%0d, want st=0 ctrl=0 cnt=0",
                 i, got.st, got.ctrl, got.cnt);
      end
    end
    reset = 1'b0;
    #1;
    count_exp = '0;
    got = observe();
    checks++;
    if (got.st !== 4'd0 || got.ctrl !== model_ctrl(0)) begin
      failures++;
      $display("FAIL mid_exec_release: got st=%0d ctrl=%h, want st=0 ctrl=%h", got.st, got.ctrl, model_ctrl(0));
    end
  endtask

  task automatic test_halt;
    push_instr(3'b111, 20);
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL halt_trace: got st=%0d ctrl=%h ill=%b hlt=%b cnt=%0d, want st=%0d ctrl=%h ill=%b hlt=%b cnt=%0d",
                 got.st, got.ctrl, got.ill, got.hlt, got.cnt, exp.st, exp.ctrl, exp.ill, exp.hlt, exp.cnt);
      end
      @(negedge clock); #1;
    end
`ifdef MULTICYCLE_CONTROL_HALT_EN
    reset = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    count_exp = '0;
`endif
    got = observe();
    checks++;
    if (got.st !== 4'd0 || got.hlt !== 1'b0 || got.cnt !== count_exp) begin
      failures++;
      $display("FAIL halt_exit: got st=%0d hlt=%b cnt=%0d, want st=0 hlt=0 cnt=%0d",
               got.st, got.hlt, got.cnt, count_exp);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_illegal();
    test_reset_mid_exec();
    test_lw();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
